// File: rtl/job_scheduler.sv
// job_scheduler: round-robin launcher sharing one accumulate controller among NREQ requesters (ready-wait timeout under SCHED_TIMEOUT_EN)
module job_scheduler #(
  parameter int NREQ = 4,
  parameter int CNT_LEN = 9,
  parameter int TO_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    ready,
  output logic                    start,
  output logic                    cntDone,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    err
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [2:0] {FLUSH, IDLE, LAUNCH, RUN, WAIT} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic [IW-1:0] ptr, pick, idx;
  logic [NREQ-1:0] oh;
  logic to, cnt_en, last;
  if (NREQ < 2 || NREQ > 8 || CNT_LEN < 1 || CNT_LEN > 255 || TO_CYC < 1 || TO_CYC > 255) begin : g_bad_param
    $error("job_scheduler: parameter out of range");
  end
`ifdef SCHED_TIMEOUT_EN
  assign to = state == WAIT && !ready && cnt == 8'(TO_CYC);
  assign cnt_en = 1'b1;
`else
  assign to = 1'b0;
  assign cnt_en = state != WAIT;
`endif
  assign last = state == RUN && cnt == 8'(CNT_LEN - 1);
  assign oh = NREQ'(1) << gnt_id;
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    nxt = state == FLUSH  ? (cnt == 8'd2 ? IDLE : FLUSH) :
          state == IDLE   ? (|req ? LAUNCH : IDLE) :
          state == LAUNCH ? RUN :
          state == RUN    ? (last ? WAIT : RUN) :
          state == WAIT   ? (ready ? IDLE : to ? FLUSH : WAIT) : FLUSH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLUSH;
      cnt <= '0;
      ptr <= '0;
      gnt_id <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt_en ? cnt + 8'd1 : cnt;
      if (state == IDLE && |req) gnt_id <= pick;
      if (state == WAIT && (ready || to)) ptr <= gnt_id == IW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end
  assign start = state == LAUNCH;
  assign cntDone = state == FLUSH || last;
  assign gnt = (state == LAUNCH || state == RUN || state == WAIT) ? oh : '0;
  assign done = (state == WAIT && ready) ? oh : '0;
  assign busy = state != IDLE;
  assign err = to;
endmodule

// File: tb/tb_job_scheduler.sv
// tb_job_scheduler: directed checks of job_scheduler against an attached controller model
module tb_job_scheduler;
  localparam logic [1:0] C_IDLE = 2'd0, C_ACC = 2'd1, C_POST = 2'd2, C_FIN = 2'd3;
  logic clk = 1'b0, rst = 1'b1, ready, start, cntDone, busy, err;
  logic [3:0] req = 4'h0, gnt, done;
  logic [1:0] gnt_id;
  logic [1:0] cst = C_ACC;
  int rmode = 0;
  int checks = 0, errors = 0;
  job_scheduler #(.NREQ(4), .CNT_LEN(9), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .start(start), .cntDone(cntDone),
    .gnt(gnt), .gnt_id(gnt_id), .done(done), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    case (cst)
      C_IDLE: cst <= start ? C_ACC : C_IDLE;
      C_ACC: cst <= cntDone ? C_POST : C_ACC;
      C_POST: cst <= C_FIN;
      default: cst <= start ? C_ACC : C_IDLE;
    endcase
  end
  assign ready = rmode == 1 ? 1'b0 : rmode == 2 ? 1'b1 : cst == C_FIN;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req = 4'h0;
    tick;
    tick;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset start: got %b exp 0", start); end
    checks++; if (cntDone !== 1'b1) begin errors++; $display("FAIL reset cntDone: got %b exp 1", cntDone); end
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset gnt: got %b exp 0000", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset gnt_id: got %0d exp 0", gnt_id); end
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset done: got %b exp 0000", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset busy: got %b exp 1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b exp 0", err); end
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      checks++; if (cntDone !== (n <= 3)) begin errors++; $display("FAIL flush cntDone n=%0d: got %b exp %b", n, cntDone, n <= 3); end
      checks++; if (busy !== (n <= 3)) begin errors++; $display("FAIL flush busy n=%0d: got %b exp %b", n, busy, n <= 3); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL flush start n=%0d: got %b exp 0", n, start); end
      if (n < 4) tick;
    end
    checks++; if (cst !== C_IDLE) begin errors++; $display("FAIL flush ctrl state: got %0d exp %0d", cst, C_IDLE); end
  endtask
  task automatic test_round_robin;
    logic [1:0] exp_w [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1};
    logic [3:0] req_nxt [8] = '{4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'ha, 4'ha, 4'h0};
    logic [3:0] w_oh;
    req = 4'hf;
    for (int j = 0; j < 8; j++) begin
      w_oh = 4'b0001 << exp_w[j];
      for (int n = 1; n <= 13; n++) begin
        tick;
        if (n == 1) begin
          checks++; if (gnt !== w_oh) begin errors++; $display("FAIL rr gnt job%0d: got %b exp %b", j, gnt, w_oh); end
          checks++; if (gnt_id !== exp_w[j]) begin errors++; $display("FAIL rr gnt_id job%0d: got %0d exp %0d", j, gnt_id, exp_w[j]); end
        end
        checks++; if (done !== (n == 12 ? w_oh : 4'h0)) begin errors++; $display("FAIL rr done job%0d n=%0d: got %b exp %b", j, n, done, n == 12 ? w_oh : 4'h0); end
        if (n == 12) req = req_nxt[j];
        if (n == 13) begin
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr idle busy job%0d: got %b exp 0", j, busy); end
        end
      end
    end
  endtask
  task automatic test_single;
    req = 4'b0001;
    for (int n = 1; n <= 13; n++) begin
      tick;
      checks++; if (start !== (n == 1)) begin errors++; $display("FAIL single start n=%0d: got %b exp %b", n, start, n == 1); end
      checks++; if (cntDone !== (n == 10)) begin errors++; $display("FAIL single cntDone n=%0d: got %b exp %b", n, cntDone, n == 10); end
      checks++; if (done !== (n == 12 ? 4'b0001 : 4'h0)) begin errors++; $display("FAIL single done n=%0d: got %b exp %b", n, done, n == 12 ? 4'b0001 : 4'h0); end
      checks++; if (ready !== (n == 12)) begin errors++; $display("FAIL single ready n=%0d: got %b exp %b", n, ready, n == 12); end
      checks++; if (gnt !== (n <= 12 ? 4'b0001 : 4'h0)) begin errors++; $display("FAIL single gnt n=%0d: got %b exp %b", n, gnt, n <= 12 ? 4'b0001 : 4'h0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL single err n=%0d: got %b exp 0", n, err); end
      checks++; if (busy !== (n <= 12)) begin errors++; $display("FAIL single busy n=%0d: got %b exp %b", n, busy, n <= 12); end
      if (n == 12) req = 4'h0;
    end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL single gnt_id kept: got %0d exp 0", gnt_id); end
  endtask
  task automatic test_drop;
    req = 4'b0100;
    for (int n = 1; n <= 16; n++) begin
      tick;
      checks++; if (gnt !== (n <= 12 ? 4'b0100 : 4'h0)) begin errors++; $display("FAIL drop gnt n=%0d: got %b exp %b", n, gnt, n <= 12 ? 4'b0100 : 4'h0); end
      checks++; if (done !== (n == 12 ? 4'b0100 : 4'h0)) begin errors++; $display("FAIL drop done n=%0d: got %b exp %b", n, done, n == 12 ? 4'b0100 : 4'h0); end
      if (n >= 13) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop idle busy n=%0d: got %b exp 0", n, busy); end
      end
      if (n == 2 || n == 13) rmode = 2;
      if (n == 5 || n == 15) rmode = 0;
      if (n == 4) req = 4'h0;
    end
  endtask
  task automatic test_rst_mid;
    req = 4'b0010;
    for (int n = 1; n <= 4; n++) begin
      tick;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rstmid gnt n=%0d: got %b exp 0010", n, gnt); end
    end
    rst = 1'b1;
    tick;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rstmid start: got %b exp 0", start); end
    checks++; if (cntDone !== 1'b1) begin errors++; $display("FAIL rstmid cntDone: got %b exp 1", cntDone); end
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL rstmid gnt: got %b exp 0000", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL rstmid gnt_id: got %0d exp 0", gnt_id); end
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL rstmid done: got %b exp 0000", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid busy: got %b exp 1", busy); end
    rst = 1'b0;
    tick;
    tick;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid idle busy: got %b exp 0", busy); end
    checks++; if (cst !== C_IDLE) begin errors++; $display("FAIL rstmid ctrl state: got %0d exp %0d", cst, C_IDLE); end
    for (int n = 1; n <= 13; n++) begin
      tick;
      if (n == 1) begin
        checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL rstmid relaunch gnt_id: got %0d exp 1", gnt_id); end
      end
      checks++; if (start !== (n == 1)) begin errors++; $display("FAIL rstmid start n=%0d: got %b exp %b", n, start, n == 1); end
      checks++; if (done !== (n == 12 ? 4'b0010 : 4'h0)) begin errors++; $display("FAIL rstmid done n=%0d: got %b exp %b", n, done, n == 12 ? 4'b0010 : 4'h0); end
      if (n == 12) req = 4'h0;
      if (n == 13) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid end busy: got %b exp 0", busy); end
      end
    end
  endtask
`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout;
    rmode = 1;
    req = 4'b0001;
    for (int n = 1; n <= 31; n++) begin
      tick;
      checks++; if (err !== (n == 27)) begin errors++; $display("FAIL timeout err n=%0d: got %b exp %b", n, err, n == 27); end
      checks++; if (done !== 4'h0) begin errors++; $display("FAIL timeout done n=%0d: got %b exp 0000", n, done); end
      if (n == 27) begin
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL timeout gnt_id: got %0d exp 0", gnt_id); end
        req = 4'h0;
      end
      if (n >= 28 && n <= 30) begin
        checks++; if (cntDone !== 1'b1) begin errors++; $display("FAIL timeout flush cntDone n=%0d: got %b exp 1", n, cntDone); end
      end
      if (n == 31) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout idle busy: got %b exp 0", busy); end
      end
    end
    rmode = 0;
  endtask
`endif
  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_drop;
    test_rst_mid;
`ifdef SCHED_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
